// File: rtl/reg_bus_master.sv
// Byte-serial register bus initiator: turns one (direction, address, length) command
// into a burst of per-byte reg_write / reg_read strobes with reg_bytecnt stepping.
module reg_bus_master #(
    parameter int pADDR_WIDTH   = 21,
    parameter int pBYTECNT_SIZE = 7
) (
    input  logic                                 usb_clk,
    input  logic                                 reset_n,
    input  logic                                 cmd_valid,
    output logic                                 cmd_ready,
    input  logic                                 cmd_write,
    input  logic [pADDR_WIDTH-pBYTECNT_SIZE-1:0] cmd_address,
    input  logic [pBYTECNT_SIZE-1:0]             cmd_len,
    input  logic [7:0]                           wr_data,
    input  logic                                 wr_valid,
    output logic                                 wr_ready,
    output logic [7:0]                           rd_data,
    output logic                                 rd_valid,
    input  logic                                 rd_ready,
    output logic                                 busy,
    output logic                                 done,
    output logic [pADDR_WIDTH-pBYTECNT_SIZE-1:0] reg_address,
    output logic [pBYTECNT_SIZE-1:0]             reg_bytecnt,
    output logic [7:0]                           write_data,
    input  logic [7:0]                           read_data,
    output logic                                 reg_read,
    output logic                                 reg_write,
    output logic                                 reg_addrvalid
);

    localparam int AW = pADDR_WIDTH - pBYTECNT_SIZE;
    localparam logic [pBYTECNT_SIZE-1:0] BYTE_ZERO = {pBYTECNT_SIZE{1'b0}};
    localparam logic [pBYTECNT_SIZE-1:0] BYTE_ONE  = {{(pBYTECNT_SIZE-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETUP   = 3'd1,
        ST_WR      = 3'd2,
        ST_WR_STB  = 3'd3,
        ST_RD_STB  = 3'd4,
        ST_RD_HOLD = 3'd5,
        ST_RD_OUT  = 3'd6,
        ST_DONE    = 3'd7
    } state_t;

    state_t                   state_q,     state_d;
    logic                     wr_dir_q,    wr_dir_d;
    logic [pBYTECNT_SIZE-1:0] len_q,       len_d;
    logic [AW-1:0]            addr_q,      addr_d;
    logic [pBYTECNT_SIZE-1:0] bytecnt_q,   bytecnt_d;
    logic [7:0]               wdata_q,     wdata_d;
    logic [7:0]               rdata_q,     rdata_d;
    logic                     rd_valid_q,  rd_valid_d;
    logic                     addrvalid_q, addrvalid_d;
    logic                     rd_stb_q,    rd_stb_d;
    logic                     wr_stb_q,    wr_stb_d;
    logic                     done_q,      done_d;

    // len is never zero inside a burst, so len-1 cannot underflow here.
    function automatic logic is_last_byte(input logic [pBYTECNT_SIZE-1:0] idx,
                                          input logic [pBYTECNT_SIZE-1:0] len);
        return (idx == (len - BYTE_ONE));
    endfunction

    // Next-state and next-output decode for the burst sequencer.
    always_comb begin
        state_d     = state_q;
        wr_dir_d    = wr_dir_q;
        len_d       = len_q;
        addr_d      = addr_q;
        bytecnt_d   = bytecnt_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        rd_valid_d  = rd_valid_q;
        addrvalid_d = addrvalid_q;
        rd_stb_d    = 1'b0;
        wr_stb_d    = 1'b0;
        done_d      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    wr_dir_d  = cmd_write;
                    len_d     = cmd_len;
                    addr_d    = cmd_address;
                    bytecnt_d = BYTE_ZERO;
                    if (cmd_len == BYTE_ZERO) begin
                        addrvalid_d = 1'b0;
                        done_d      = 1'b1;
                        state_d     = ST_DONE;
                    end else begin
                        addrvalid_d = 1'b1;
                        state_d     = ST_SETUP;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETUP: begin
                if (wr_dir_q) begin
                    state_d = ST_WR;
                end else begin
                    rd_stb_d = 1'b1;
                    state_d  = ST_RD_STB;
                end
            end
            ST_WR: begin
                if (wr_valid) begin
                    wdata_d  = wr_data;
                    wr_stb_d = 1'b1;
                    state_d  = ST_WR_STB;
                end else begin
                    state_d = ST_WR;
                end
            end
            ST_WR_STB: begin
                if (is_last_byte(bytecnt_q, len_q)) begin
                    addrvalid_d = 1'b0;
                    bytecnt_d   = BYTE_ZERO;
                    done_d      = 1'b1;
                    state_d     = ST_DONE;
                end else begin
                    bytecnt_d = bytecnt_q + BYTE_ONE;
                    state_d   = ST_WR;
                end
            end
            ST_RD_STB: begin
                rd_stb_d = 1'b1;
                state_d  = ST_RD_HOLD;
            end
            // Sampling one cycle after the strobe rises suits registered responders too.
            ST_RD_HOLD: begin
                rdata_d    = read_data;
                rd_valid_d = 1'b1;
                state_d    = ST_RD_OUT;
            end
            ST_RD_OUT: begin
                if (rd_ready) begin
                    rd_valid_d = 1'b0;
                    if (is_last_byte(bytecnt_q, len_q)) begin
                        addrvalid_d = 1'b0;
                        bytecnt_d   = BYTE_ZERO;
                        done_d      = 1'b1;
                        state_d     = ST_DONE;
                    end else begin
                        bytecnt_d = bytecnt_q + BYTE_ONE;
                        rd_stb_d  = 1'b1;
                        state_d   = ST_RD_STB;
                    end
                end else begin
                    state_d = ST_RD_OUT;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                addrvalid_d = 1'b0;
                rd_valid_d  = 1'b0;
                bytecnt_d   = BYTE_ZERO;
                state_d     = ST_IDLE;
            end
        endcase
    end

    // State and registered-output flops; reset drops the bus immediately.
    always_ff @(posedge usb_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            wr_dir_q    <= 1'b0;
            len_q       <= BYTE_ZERO;
            addr_q      <= {AW{1'b0}};
            bytecnt_q   <= BYTE_ZERO;
            wdata_q     <= 8'h00;
            rdata_q     <= 8'h00;
            rd_valid_q  <= 1'b0;
            addrvalid_q <= 1'b0;
            rd_stb_q    <= 1'b0;
            wr_stb_q    <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_dir_q    <= wr_dir_d;
            len_q       <= len_d;
            addr_q      <= addr_d;
            bytecnt_q   <= bytecnt_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            rd_valid_q  <= rd_valid_d;
            addrvalid_q <= addrvalid_d;
            rd_stb_q    <= rd_stb_d;
            wr_stb_q    <= wr_stb_d;
            done_q      <= done_d;
        end
    end

    assign cmd_ready     = (state_q == ST_IDLE);
    assign busy          = (state_q != ST_IDLE);
    assign wr_ready      = (state_q == ST_WR);
    assign rd_data       = rdata_q;
    assign rd_valid      = rd_valid_q;
    assign done          = done_q;
    assign reg_address   = addr_q;
    assign reg_bytecnt   = bytecnt_q;
    assign write_data    = wdata_q;
    assign reg_read      = rd_stb_q;
    assign reg_write     = wr_stb_q;
    assign reg_addrvalid = addrvalid_q;

endmodule

// File: tb/tb_reg_bus_master.sv
// Randomised bench for reg_bus_master: a cycle timeline built from the burst latency
// rules plus a register-file responder, with literal expectations pinning the model.
module tb_reg_bus_master;

    localparam int AW   = 14;
    localparam int LW   = 7;
    localparam int MAXC = 4096;

    logic          usb_clk = 1'b0;
    logic          reset_n;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_address;
    logic [LW-1:0] cmd_len;
    logic [7:0]    wr_data;
    logic          wr_valid, wr_ready;
    logic [7:0]    rd_data;
    logic          rd_valid, rd_ready;
    logic          busy, done;
    logic [AW-1:0] reg_address;
    logic [LW-1:0] reg_bytecnt;
    logic [7:0]    write_data, read_data;
    logic          reg_read, reg_write, reg_addrvalid;

    int checks   = 0;
    int failures = 0;

    always #5 usb_clk = ~usb_clk;

    reg_bus_master #(.pADDR_WIDTH(21), .pBYTECNT_SIZE(7)) dut (
        .usb_clk(usb_clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_address(cmd_address), .cmd_len(cmd_len),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .busy(busy), .done(done),
        .reg_address(reg_address), .reg_bytecnt(reg_bytecnt),
        .write_data(write_data), .read_data(read_data),
        .reg_read(reg_read), .reg_write(reg_write), .reg_addrvalid(reg_addrvalid)
    );

    // Responder register file indexed by {address[3:0], bytecnt}; model_mem is the bench's own copy.
    logic [7:0] resp_mem  [0:2047] = '{default: 8'h00};
    logic [7:0] model_mem [0:2047] = '{default: 8'h00};

    always @(posedge usb_clk) begin
        if (reg_write) resp_mem[{reg_address[3:0], reg_bytecnt}] <= write_data;
    end
    assign read_data = reg_read ? resp_mem[{reg_address[3:0], reg_bytecnt}] : 8'h00;

    // Per-cycle handshake stimulus and expected timeline (index = cycles after acceptance).
    bit         wv     [MAXC];
    bit         rr     [MAXC];
    bit         e_wstb [MAXC];
    bit         e_rstb [MAXC];
    bit         e_wrr  [MAXC];
    bit         e_rdv  [MAXC];
    int         e_k    [MAXC];
    int         win    [MAXC];
    logic [7:0] e_wd   [MAXC];
    logic [7:0] e_rd   [MAXC];
    logic [7:0] wdata  [128];

    int          obs_done_c, obs_first_wr, obs_last_wr, obs_nwr;
    logic [63:0] obs_rd;

    task automatic chk(input string nm, input int c, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", nm, c, act, exp);
        end
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_cmd_ready"}, -1, 64'(cmd_ready), 64'd1);
        chk({tag, "_busy"}, -1, 64'(busy), 64'd0);
        chk({tag, "_wr_ready"}, -1, 64'(wr_ready), 64'd0);
        chk({tag, "_rd_valid"}, -1, 64'(rd_valid), 64'd0);
        chk({tag, "_rd_data"}, -1, 64'(rd_data), 64'd0);
        chk({tag, "_done"}, -1, 64'(done), 64'd0);
        chk({tag, "_reg_read"}, -1, 64'(reg_read), 64'd0);
        chk({tag, "_reg_write"}, -1, 64'(reg_write), 64'd0);
        chk({tag, "_addrvalid"}, -1, 64'(reg_addrvalid), 64'd0);
        chk({tag, "_write_data"}, -1, 64'(write_data), 64'd0);
        chk({tag, "_reg_address"}, -1, 64'(reg_address), 64'd0);
        chk({tag, "_reg_bytecnt"}, -1, 64'(reg_bytecnt), 64'd0);
    endtask

    task automatic set_handshakes(input int pct);
        for (int c = 0; c < MAXC; c++) begin
            wv[c] = (c < 600) ? (int'($urandom_range(99)) < pct) : 1'b1;
            rr[c] = (c < 600) ? (int'($urandom_range(99)) < pct) : 1'b1;
        end
    endtask

    // Build the expected timeline, then issue the command and compare every cycle until idle.
    task automatic run_cmd(input logic wr, input logic [AW-1:0] addr, input int len, input int abort_c);
        int         done_c, t, r, ca;
        logic [10:0] mi;
        for (int c = 0; c < MAXC; c++) begin
            e_wstb[c] = 1'b0; e_rstb[c] = 1'b0; e_wrr[c] = 1'b0; e_rdv[c] = 1'b0;
            e_k[c] = -1; win[c] = -1; e_wd[c] = 8'h00; e_rd[c] = 8'h00;
        end
        if (len == 0) begin
            done_c = 1;
        end else if (wr) begin
            e_k[1] = 0;
            t = 1;
            for (int k = 0; k < len; k++) begin
                ca = t + 1;
                while (!wv[ca]) ca++;
                for (int x = t + 1; x <= ca; x++) begin
                    e_wrr[x] = 1'b1; e_k[x] = k; win[x] = k;
                end
                t = ca + 1;
                e_wstb[t] = 1'b1; e_k[t] = k; e_wd[t] = wdata[k];
            end
            done_c = t + 1;
            for (int k = 0; k < len; k++) begin
                mi = {addr[3:0], 7'(k)};
                model_mem[mi] = wdata[k];
            end
        end else begin
            e_k[1] = 0;
            r = 2;
            for (int k = 0; k < len; k++) begin
                mi = {addr[3:0], 7'(k)};
                e_rstb[r] = 1'b1; e_rstb[r+1] = 1'b1; e_k[r] = k; e_k[r+1] = k;
                ca = r + 1;
                do begin
                    ca++;
                    e_rdv[ca] = 1'b1; e_k[ca] = k; e_rd[ca] = model_mem[mi];
                end while (!rr[ca]);
                r = ca + 1;
            end
            done_c = r;
        end

        obs_done_c = -1; obs_first_wr = -1; obs_last_wr = -1; obs_nwr = 0; obs_rd = 64'd0;
        wr_valid = 1'b0; rd_ready = 1'b0;
        cmd_valid = 1'b1; cmd_write = wr; cmd_address = addr; cmd_len = LW'(len);
        @(posedge usb_clk);
        for (int c = 1; c <= done_c + 1; c++) begin
            @(negedge usb_clk);
            chk("busy", c, 64'(busy), 64'(c <= done_c));
            chk("cmd_ready", c, 64'(cmd_ready), 64'(c > done_c));
            chk("addrvalid", c, 64'(reg_addrvalid), 64'(len > 0 && c < done_c));
            chk("done", c, 64'(done), 64'(c == done_c));
            chk("reg_write", c, 64'(reg_write), 64'(e_wstb[c]));
            chk("reg_read", c, 64'(reg_read), 64'(e_rstb[c]));
            chk("wr_ready", c, 64'(wr_ready), 64'(e_wrr[c]));
            chk("rd_valid", c, 64'(rd_valid), 64'(e_rdv[c]));
            chk("reg_address", c, 64'(reg_address), 64'(addr));
            if (e_k[c] >= 0) chk("bytecnt", c, 64'(reg_bytecnt), 64'(e_k[c]));
            if (c == done_c) chk("bytecnt_done", c, 64'(reg_bytecnt), 64'd0);
            if (e_wstb[c]) chk("write_data", c, 64'(write_data), 64'(e_wd[c]));
            if (e_rdv[c]) chk("rd_data", c, 64'(rd_data), 64'(e_rd[c]));

            if (done === 1'b1 && obs_done_c < 0) obs_done_c = c;
            if (reg_write === 1'b1) begin
                if (obs_first_wr < 0) obs_first_wr = c;
                obs_last_wr = c;
                obs_nwr++;
            end
            if (e_rdv[c] && rr[c]) obs_rd = {obs_rd[55:0], rd_data};
            if (c == abort_c) return;

            if (c <= done_c) begin
                cmd_valid   = 1'($urandom);
                cmd_write   = 1'($urandom);
                cmd_address = AW'($urandom);
                cmd_len     = LW'($urandom);
            end else begin
                cmd_valid = 1'b0;
            end
            wr_valid = wv[c];
            wr_data  = (win[c] >= 0) ? wdata[win[c]] : 8'($urandom);
            rd_ready = rr[c];
        end
    endtask

    initial begin
        logic [63:0] name_bytes;
        logic [63:0] pattern;
        int          len;

        name_bytes = 64'h41726d5472616365;
        reset_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_address = '0; cmd_len = '0;
        wr_data = 8'h00; wr_valid = 1'b0; rd_ready = 1'b0;
        #2;
        chk_reset_state("por");
        @(negedge usb_clk);
        @(negedge usb_clk);
        reset_n = 1'b1;
        @(negedge usb_clk);
        chk("idle_ready", 0, 64'(cmd_ready), 64'd1);

        // Write 0x11..0x88 to address 0x08 with no stalls.
        set_handshakes(100);
        for (int k = 0; k < 8; k++) wdata[k] = 8'((k + 1) * 17);
        run_cmd(1'b1, 14'h0008, 8, 0);
        chk("wr8_done_cycle", 0, 64'(obs_done_c), 64'd18);
        chk("wr8_first_strobe", 0, 64'(obs_first_wr), 64'd3);
        chk("wr8_last_strobe", 0, 64'(obs_last_wr), 64'd17);
        chk("wr8_strobe_count", 0, 64'(obs_nwr), 64'd8);
        for (int k = 7; k >= 0; k--) pattern = {pattern[55:0], resp_mem[1024 + k]};
        chk("wr8_regfile", 0, pattern, 64'h8877665544332211);

        // Store the name bytes at address 0 (stalled writes), then read back.
        set_handshakes(70);
        for (int k = 0; k < 8; k++) wdata[k] = name_bytes[63 - 8*k -: 8];
        run_cmd(1'b1, 14'h0000, 8, 0);
        set_handshakes(100);
        run_cmd(1'b0, 14'h0000, 8, 0);
        chk("rd8_done_cycle", 0, 64'(obs_done_c), 64'd26);
        chk("rd8_bytes", 0, obs_rd, 64'h41726d5472616365);

        // rd_ready low for five cycles while byte 2 is presented.
        set_handshakes(100);
        for (int c = 10; c < 15; c++) rr[c] = 1'b0;
        run_cmd(1'b0, 14'h0000, 8, 0);
        chk("rdstall_done_cycle", 0, 64'(obs_done_c), 64'd31);
        chk("rdstall_bytes", 0, obs_rd, 64'h41726d5472616365);

        // wr_valid low for four cycles before byte 1.
        set_handshakes(100);
        for (int c = 4; c < 8; c++) wv[c] = 1'b0;
        for (int k = 0; k < 3; k++) wdata[k] = 8'($urandom);
        run_cmd(1'b1, 14'h0203, 3, 0);
        chk("wrgap_done_cycle", 0, 64'(obs_done_c), 64'd12);
        chk("wrgap_first_strobe", 0, 64'(obs_first_wr), 64'd3);
        chk("wrgap_last_strobe", 0, 64'(obs_last_wr), 64'd11);

        // Zero-length command.
        run_cmd(1'b0, 14'h0155, 0, 0);
        chk("len0_done_cycle", 0, 64'(obs_done_c), 64'd1);

        // Reset while byte 4 of a read sits in the output register.
        set_handshakes(100);
        run_cmd(1'b0, 14'h0010, 8, 16);
        reset_n = 1'b0;
        #1;
        chk_reset_state("midburst");
        cmd_valid = 1'b0; wr_valid = 1'b0; rd_ready = 1'b0;
        @(negedge usb_clk);
        chk_reset_state("held");
        reset_n = 1'b1;
        @(negedge usb_clk);
        chk("post_reset_ready", 0, 64'(cmd_ready), 64'd1);
        chk("post_reset_busy", 0, 64'(busy), 64'd0);
        chk("post_reset_strobes", 0, 64'({reg_read, reg_write}), 64'd0);
        set_handshakes(60);
        run_cmd(1'b0, 14'h0010, 8, 0);
        chk("post_reset_bytes", 0, obs_rd, 64'h41726d5472616365);

        // Randomised commands with random handshake stalls and ignored cmd_* noise.
        for (int n = 0; n < 30; n++) begin
            set_handshakes(60);
            for (int k = 0; k < 128; k++) wdata[k] = 8'($urandom);
            len = ($urandom_range(7) == 0) ? 0 : int'($urandom_range(1, 20));
            run_cmd(1'($urandom), AW'($urandom), len, 0);
            if ($urandom_range(3) == 0) begin
                repeat (int'($urandom_range(1, 3))) begin
                    @(negedge usb_clk);
                    chk("gap_ready", 0, 64'(cmd_ready), 64'd1);
                    chk("gap_strobes", 0, 64'({reg_read, reg_write, reg_addrvalid}), 64'd0);
                end
            end
        end

        // Maximum-length bursts.
        set_handshakes(50);
        for (int k = 0; k < 128; k++) wdata[k] = 8'($urandom);
        run_cmd(1'b1, 14'h1235, 127, 0);
        chk("max_wr_count", 0, 64'(obs_nwr), 64'd127);
        set_handshakes(50);
        run_cmd(1'b0, 14'h1235, 127, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/reg_bus_master.md
Name: reg_bus_master

Overview:
- Initiator for the byte-serial register bus that cw305_usb_reg_fe drives. It converts one command (direction, address, byte length) into a burst of per-byte reg_write or reg_read strobes, with reg_bytecnt stepping through the bytes.
- Lets an on-FPGA agent (debug sequencer, self-test engine) configure trace registers with no USB host.
- All register-block outputs fan in here through read_data.

Parameters:
- pADDR_WIDTH, 21, full register address width including the byte-count field.
- pBYTECNT_SIZE, 7, width of reg_bytecnt and cmd_len.

Ports:
- usb_clk  in  1  sole clock.
- reset_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE.
- cmd_write  in  1  1 = write burst, 0 = read burst.
- cmd_address  in  pADDR_WIDTH-pBYTECNT_SIZE  register address.
- cmd_len  in  pBYTECNT_SIZE  bytes in the burst, 0..127.
- wr_data  in  8  write byte stream.
- wr_valid  in  1  write byte available.
- wr_ready  out  1  write byte accepted.
- rd_data  out  8  read byte stream.
- rd_valid  out  1  read byte available.
- rd_ready  in  1  read byte consumed.
- busy  out  1  high when state is not IDLE.
- done  out  1  one-cycle pulse at burst end.
- reg_address  out  pADDR_WIDTH-pBYTECNT_SIZE  bus address.
- reg_bytecnt  out  pBYTECNT_SIZE  current byte index.
- write_data  out  8  bus write byte.
- read_data  in  8  bus read byte, ORed responder outputs.
- reg_read  out  1  read strobe.
- reg_write  out  1  write strobe.
- reg_addrvalid  out  1  address valid.

Behaviour:
- Reset:
  - reset_n low clears every register immediately: state=IDLE, all strobes, addrvalid, done, rd_valid, write_data, rd_data, reg_address, reg_bytecnt = 0.
  - cmd_ready=1 while in reset. Mid-burst reset aborts with no further strobes.
- Outputs:
  - All bus outputs, rd_data, rd_valid and done are registered.
  - cmd_ready, wr_ready and busy decode directly from the state register.
- FSM: IDLE, SETUP, WR, WR_STB, RD_STB, RD_HOLD, RD_OUT, DONE.
- IDLE:
  - On cmd_valid&cmd_ready, latch direction and len; load reg_address; reg_bytecnt=0.
  - len=0: go to DONE with addrvalid kept low.
  - Otherwise set reg_addrvalid=1 and go to SETUP.
- SETUP: one cycle with addrvalid high and no strobe. Go to WR if write, else RD_STB.
- WR:
  - wr_ready=1.
  - On wr_valid, write_data<=wr_data, then go to WR_STB.
  - Waits indefinitely for wr_valid.
- WR_STB:
  - reg_write=1 for exactly this cycle, with reg_bytecnt = byte index.
  - Then: if index==len-1 go to DONE; else bytecnt+1 and go to WR.
- RD_STB, RD_HOLD:
  - reg_read=1 for both cycles; bytecnt stable.
  - read_data is sampled into rd_data at the end of RD_HOLD. This is one cycle after the strobe rises, and valid for both combinational and registered responders.
- RD_OUT:
  - rd_valid=1 and rd_data held until rd_ready.
  - On handshake: last byte → DONE; else bytecnt+1 → RD_STB.
  - No strobe is issued while stalled.
- DONE: reg_addrvalid=0, done=1 for one cycle, reg_bytecnt=0, then IDLE.
- reg_address and the latched len are held constant for the whole burst. cmd_* changes during busy are ignored.
- reg_bytecnt never wraps: maximum index is 126, since len ≤ 127.
- reg_read and reg_write are never high together, and never high while addrvalid is low.
- Latency, counting the acceptance edge as cycle 0:
  - Write N bytes, wr_valid held high: SETUP in cycle 1; strobe k in cycle 3+2k; done in cycle 2+2N.
  - Read N bytes, rd_ready held high: reg_read in cycles 2+3k and 3+3k; rd_valid in cycle 4+3k; done in cycle 2+3N.

Test Plan:
- Write address 0x08, len 8, wr_data 0x11..0x88 back-to-back:
  - 8 single-cycle reg_write pulses in cycles 3,5,..,17 with bytecnt 0..7 and matching write_data.
  - addrvalid high in cycles 1..17; done in cycle 18.
  - A register-block model shows pattern 0x8877665544332211.
- Read address 0x00, len 8, against a model returning the ASCII name bytes:
  - rd_data sequence 0x41,0x72,0x6d,0x54,0x72,0x61,0x63,0x65; done in cycle 26.
- Read with rd_ready low for 5 cycles on byte 2:
  - rd_valid and rd_data held; bytecnt stays 2; no reg_read during the stall.
  - Burst completes 5 cycles late.
- Write len 3 with wr_valid low for 4 cycles before byte 1:
  - wr_ready stays high; no reg_write during the gap; bytecnt 0,1,2 in order.
- cmd_len=0: done in cycle 1; addrvalid, reg_read and reg_write never assert; cmd_ready is back high in cycle 2.
- Assert reset_n low during RD_OUT of byte 4:
  - All outputs are 0 in the same cycle, asynchronously.
  - After release: cmd_ready=1, busy=0, and a new read succeeds.
